// File: rtl/ll_control_if.sv
// Bus between the lander control unit and its memory/ALU datapath.
// wen is a one-cycle strobe with no back-pressure: memory latches alt/vel/thrust on the edge that ends it.
interface ll_control_if;
  logic [15:0] alt;
  logic [15:0] vel;
  logic [15:0] thrust;
  logic [15:0] alt_n;
  logic        wen;
  logic        land;
  logic        crash;

  modport master (
    output alt, vel, thrust, alt_n,
    input  wen, land, crash
  );

  modport slave (
    input  alt, vel, thrust, alt_n,
    output wen, land, crash
  );
endinterface

// File: rtl/ll_control.sv
// Lunar-lander sequencer: prescaled update cadence, one write strobe per update,
// touchdown detection from the ALU lookahead and safe/crash classification.
module ll_control #(
  parameter int          PRESCALE   = 25,
  parameter logic [15:0] SAFE_VEL   = 16'h9970,
  parameter logic [15:0] MAX_THRUST = 16'h0005
) (
  input  logic           clk,
  input  logic           rst,
  ll_control_if.slave    bus,
  output logic [2:0]     state_dbg,
  output logic           alt_pos_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    SET   = 3'd2,
    LAND  = 3'd3,
    CRASH = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       wen_q;
  logic       land_q;
  logic       crash_q;
  logic       tick;
  logic       touch;
  logic       bad;

  assign tick  = (cnt == 8'(PRESCALE - 1));
  assign touch = (bus.alt_n == 16'h0000) || (bus.alt_n[15:12] >= 4'd5);
  // Unsigned compare is sound: BCD ten's-complement negatives keep magnitude order.
  assign bad   = (bus.thrust > MAX_THRUST) ||
                 ((bus.vel[15:12] >= 4'd5) && (bus.vel <= SAFE_VEL));

  assign bus.wen   = wen_q;
  assign bus.land  = land_q;
  assign bus.crash = crash_q;

  assign state_dbg   = state;
  // alt is observed only; decisions use the alt_n lookahead.
  assign alt_pos_dbg = (bus.alt[15:12] < 4'd5) && (bus.alt != 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      wen_q   <= 1'b0;
      land_q  <= 1'b0;
      crash_q <= 1'b0;
    end else begin
      if (state != LAND && state != CRASH) begin
        cnt <= tick ? 8'd0 : cnt + 8'd1;
      end
      wen_q <= 1'b0;
      case (state)
        IDLE: begin
          if (tick) state <= CALC;
        end
        CALC: begin
          if (touch && bad) begin
            state   <= CRASH;
            crash_q <= 1'b1;
          end else if (touch) begin
            state  <= LAND;
            land_q <= 1'b1;
          end else begin
            state <= SET;
            wen_q <= 1'b1;
          end
        end
        SET: begin
          state <= IDLE;
        end
        LAND: begin
          state <= LAND;
        end
        CRASH: begin
          state <= CRASH;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ll_control.sv
// Bench for ll_control: directed scenarios plus randomized runs checked against
// an integer-arithmetic model of the update cadence and landing rules.
module tb_ll_control;
  localparam int          P      = 4;
  localparam logic [15:0] SAFE_V = 16'h9970;
  localparam logic [15:0] MAX_T  = 16'h0005;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;
  logic       alt_pos_dbg;

  ll_control_if bus ();

  ll_control #(.PRESCALE(P), .SAFE_VEL(SAFE_V), .MAX_THRUST(MAX_T)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .state_dbg   (state_dbg),
    .alt_pos_dbg (alt_pos_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] got;
  logic [2:0] exp;
  int         m_edge;
  bit         m_done;
  bit         m_bad;

  // Signed value of a 4-digit BCD ten's-complement word.
  function automatic int bcd_val(input logic [15:0] b);
    int m;
    m = int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    return (b[15:12] >= 4'd5) ? m - 10000 : m;
  endfunction

  function automatic logic [15:0] rand_bcd(input int top_lo, input int top_hi);
    logic [15:0] r;
    r[15:12] = 4'($urandom_range(top_hi, top_lo));
    r[11:8]  = 4'($urandom_range(9, 0));
    r[7:4]   = 4'($urandom_range(9, 0));
    r[3:0]   = 4'($urandom_range(9, 0));
    return r;
  endfunction

  task automatic model_reset();
    m_edge = 0;
    m_done = 1'b0;
    m_bad  = 1'b0;
    exp_q.delete();
  endtask

  // Updates are decided on edges k*P+1; expected {wen,land,crash} after each edge.
  task automatic model_edge();
    bit fire;
    fire   = 1'b0;
    m_edge = m_edge + 1;
    if (!m_done && m_edge > P && ((m_edge - 1) % P) == 0) begin
      if (bcd_val(bus.alt_n) <= 0) begin
        m_done = 1'b1;
        m_bad  = (bcd_val(bus.thrust) > bcd_val(MAX_T)) || (bcd_val(bus.vel) <= bcd_val(SAFE_V));
      end else begin
        fire = 1'b1;
      end
    end
    exp_q.push_back({fire, m_done && !m_bad, m_done && m_bad});
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_inputs(input logic [15:0] a_n, input logic [15:0] v, input logic [15:0] t);
    bus.alt_n  = a_n;
    bus.vel    = v;
    bus.thrust = t;
    bus.alt    = 16'h0100;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    set_inputs(16'h4499, 16'h0000, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {bus.wen, bus.land, bus.crash};
      checks++;
      if (got !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d got wen/land/crash=%b expected 000", i, got);
      end
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 22; i++) begin
      step();
      got = {bus.wen, bus.land, bus.crash};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_cadence edge %0d got wen/land/crash=%b expected %b", m_edge, got, exp);
      end
    end
  endtask

  task automatic test_fixed(input string name, input logic [15:0] a_n, input logic [15:0] v,
                            input logic [15:0] t, input int edges);
    set_inputs(a_n, v, t);
    apply_reset(2);
    for (int i = 0; i < edges; i++) begin
      step();
      got = {bus.wen, bus.land, bus.crash};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s edge %0d got wen/land/crash=%b expected %b", name, m_edge, got, exp);
      end
    end
  endtask

  task automatic test_reset_mid_set();
    set_inputs(16'h0500, 16'h9990, 16'h0002);
    apply_reset(2);
    for (int i = 0; i < P + 1; i++) begin
      step();
      got = {bus.wen, bus.land, bus.crash};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_set_pre edge %0d got wen/land/crash=%b expected %b", m_edge, got, exp);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.wen !== 1'b0) begin
      errors++;
      $display("FAIL mid_set_abort got wen=%b expected 0", bus.wen);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      step();
      got = {bus.wen, bus.land, bus.crash};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL mid_set_post edge %0d got wen/land/crash=%b expected %b", m_edge, got, exp);
      end
    end
  endtask

  task automatic test_reset_in_crash();
    set_inputs(16'h0000, 16'h9950, 16'h0000);
    apply_reset(2);
    for (int i = 0; i < 8; i++) begin
      step();
      got = {bus.wen, bus.land, bus.crash};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL crash_pre edge %0d got wen/land/crash=%b expected %b", m_edge, got, exp);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.crash !== 1'b0) begin
      errors++;
      $display("FAIL crash_clear got crash=%b expected 0", bus.crash);
    end
    set_inputs(16'h0300, 16'h0000, 16'h0001);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      got = {bus.wen, bus.land, bus.crash};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL crash_post edge %0d got wen/land/crash=%b expected %b", m_edge, got, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a_n;
    for (int it = 0; it < 6; it++) begin
      set_inputs(16'h1000, 16'h0000, 16'h0000);
      apply_reset(2);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(7, 0) == 0) begin
          a_n = ($urandom_range(1, 0) == 0) ? 16'h0000 : rand_bcd(5, 9);
        end else begin
          a_n = rand_bcd(0, 4);
          if (a_n == 16'h0000) a_n = 16'h0001;
        end
        bus.alt_n  = a_n;
        bus.vel    = ($urandom_range(1, 0) == 0) ? rand_bcd(9, 9) : rand_bcd(0, 9);
        bus.thrust = 16'($urandom_range(9, 0));
        step();
        got = {bus.wen, bus.land, bus.crash};
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random it %0d edge %0d got wen/land/crash=%b expected %b", it, m_edge, got, exp);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    set_inputs(16'h4499, 16'h0000, 16'h0000);
    model_reset();
    test_reset();
    test_fixed("safe_landing", 16'h9995, 16'h9990, 16'h0005, 30);
    test_fixed("vel_at_limit", 16'h0000, 16'h9970, 16'h0005, 10);
    test_fixed("vel_above_limit", 16'h0000, 16'h9971, 16'h0005, 10);
    test_fixed("thrust_crash", 16'h9998, 16'h9995, 16'h0006, 10);
    test_fixed("no_touch_low", 16'h0001, 16'h9950, 16'h0009, 18);
    test_fixed("no_touch_high", 16'h4999, 16'h0000, 16'h0000, 18);
    test_reset_mid_set();
    test_reset_in_crash();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
